// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit direction counters.
// It predicts taken branches at fetch and redirects on an execute-stage misprediction.
module pc_predict_unit #(
  parameter int AW = 32,
  parameter int BTB_DEPTH = 16,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_pc,
  input  logic          ex_is_branch,
  input  logic          ex_is_jump,
  input  logic          ex_taken,
  input  logic [AW-1:0] ex_target,
  input  logic          ex_pred_taken,
  input  logic [AW-1:0] ex_pred_target,
  output logic          mispredict
);
  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = AW - IW - 2;

  logic [BTB_DEPTH-1:0] valid;
  logic [TW-1:0]        tag [BTB_DEPTH];
  logic [AW-3:0]        tgt [BTB_DEPTH];
  logic [1:0]           ctr [BTB_DEPTH];

  logic [IW-1:0] f_idx;
  logic          f_hit;
  logic          resolve;
  logic [AW-1:0] redirect;
  logic [AW-1:0] next_pc;
  logic [IW-1:0] u_idx;
  logic [TW-1:0] u_tag;
  logic          u_hit;
  logic [1:0]    u_ctr;
  logic          wr_ctr;
  logic          wr_entry;

  // Fetch-side lookup reads only stored state, so a same-cycle write is not seen.
  assign f_idx       = pc[IW+1:2];
  assign f_hit       = valid[f_idx] && (tag[f_idx] == pc[AW-1:IW+2]);
  assign pred_taken  = f_hit & ctr[f_idx][1];
  assign pred_target = {tgt[f_idx], 2'b00};
  assign pc_plus4    = pc + AW'(4);

  assign resolve    = ex_valid & (ex_is_branch | ex_is_jump);
  assign mispredict = resolve & ((ex_taken != ex_pred_taken) |
                                 (ex_taken & (ex_target != ex_pred_target)));
  assign redirect   = ex_taken ? {ex_target[AW-1:2], 2'b00} : ex_pc + AW'(4);

  always_comb begin
    next_pc = pc_plus4;
    if (mispredict)      next_pc = redirect;
    else if (stall)      next_pc = pc;
    else if (pred_taken) next_pc = pred_target;
  end

  assign u_idx    = ex_pc[IW+1:2];
  assign u_tag    = ex_pc[AW-1:IW+2];
  assign u_hit    = valid[u_idx] && (tag[u_idx] == u_tag);
  assign wr_entry = resolve & ex_taken;
  assign wr_ctr   = resolve & (ex_taken | u_hit);

  // Counter policy: fresh branches start weakly taken, jumps are pinned strongly taken.
  always_comb begin
    u_ctr = ctr[u_idx];
    if (ex_taken) begin
      if (ex_is_jump)               u_ctr = 2'b11;
      else if (!u_hit)              u_ctr = 2'b10;
      else if (ctr[u_idx] != 2'b11) u_ctr = ctr[u_idx] + 2'd1;
    end else if (ctr[u_idx] != 2'b00) begin
      u_ctr = ctr[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag[i] <= '0;
        tgt[i] <= '0;
        ctr[i] <= 2'b01;
      end
    end else begin
      pc <= next_pc;
      if (wr_ctr) ctr[u_idx] <= u_ctr;
      if (wr_entry) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
        tgt[u_idx]   <= ex_target[AW-1:2];
      end
    end
  end
endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios plus randomized resolutions
// compared against an array-based predictor model and an expected-PC queue.
module tb_pc_predict_unit;
  localparam int DEPTH = 16;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc, pc_plus4, pred_target;
  logic        pred_taken, mispredict;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
  logic        ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Reference predictor state, one slot per BTB line.
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  logic [31:0] exp_q [$];

  pc_predict_unit #(.AW(32), .BTB_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 1;
    end
    exp_q.delete();
    exp_q.push_back(RST_PC);
  endtask

  task automatic set_ex(input bit v, input bit br, input bit jmp, input bit tk,
                        input logic [31:0] p, input logic [31:0] t,
                        input bit ptk, input logic [31:0] pt);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
    ex_pc = p; ex_target = t; ex_pred_taken = ptk; ex_pred_target = pt;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 0, '0, '0, 0, '0);
  endtask

  // One clock: check outputs mid-cycle, advance the model, return at posedge+1.
  task automatic step();
    logic [31:0] cur, nxt, ptgt, utag;
    int i, j;
    bit hit, ptk, mis, uhit;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'(exp_q.size()), 32'd1);
      cur = RST_PC;
    end else begin
      cur = exp_q.pop_front();
    end
    i = int'((cur / 4) % DEPTH);
    hit = m_valid[i] && (m_tag[i] == cur / (4 * DEPTH));
    ptk = hit && (m_ctr[i] >= 2);
    ptgt = m_tgt[i];
    mis = ex_valid && (ex_is_branch || ex_is_jump) &&
          ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
    check("pc", pc, cur);
    check("pc_plus4", pc_plus4, cur + 32'd4);
    check("pred_taken", 32'(pred_taken), 32'(ptk));
    check("pred_target", pred_target, ptgt);
    check("mispredict", 32'(mispredict), 32'(mis));
    if (mis)        nxt = ex_taken ? (ex_target & ~32'd3) : ex_pc + 32'd4;
    else if (stall) nxt = cur;
    else if (ptk)   nxt = ptgt;
    else            nxt = cur + 32'd4;
    exp_q.push_back(nxt);
    if (ex_valid && (ex_is_branch || ex_is_jump)) begin
      j = int'((ex_pc / 4) % DEPTH);
      utag = ex_pc / (4 * DEPTH);
      uhit = m_valid[j] && (m_tag[j] == utag);
      if (ex_taken) begin
        if (ex_is_jump)  m_ctr[j] = 3;
        else if (!uhit)  m_ctr[j] = 2;
        else             m_ctr[j] = (m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1;
        m_valid[j] = 1'b1;
        m_tag[j] = utag;
        m_tgt[j] = ex_target & ~32'd3;
      end else if (uhit) begin
        m_ctr[j] = (m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Redirect fetch to a via a not-taken branch at a-4 that was predicted taken.
  task automatic go_to(input logic [31:0] a);
    set_ex(1, 1, 0, 0, a - 32'd4, '0, 1, '0);
    step();
    idle();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, RST_PC);
    check("midrst_pred", 32'(pred_taken), 32'd0);
    check("midrst_tgt", pred_target, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", pc, RST_PC);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] t;
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_pred", 32'(pred_taken), 32'd0);
    check("rst_pc4", pc_plus4, 32'h0000_3004);
    rst_n = 1'b1;
    repeat (3) step();
    check("seq_pc", pc, 32'h0000_300C);
    step();

    // Loop training at 0x3010.
    set_ex(1, 1, 0, 1, 32'h3010, 32'h3000, 0, '0);
    step(); idle();
    check("train_redirect", pc, 32'h0000_3000);
    repeat (4) step();
    check("train_fetch_pc", pc, 32'h0000_3010);
    check("train_pred", 32'(pred_taken), 32'd1);
    check("train_tgt", pred_target, 32'h0000_3000);
    set_ex(1, 1, 0, 1, 32'h3010, 32'h3000, 1, 32'h3000);
    #1 check("train_no_mis", 32'(mispredict), 32'd0);
    step(); idle();

    // Hysteresis from a saturated counter.
    set_ex(1, 1, 0, 0, 32'h3010, 32'h3000, 1, 32'h3000);
    #1 check("hyst_mis1", 32'(mispredict), 32'd1);
    step(); idle();
    check("hyst_redirect", pc, 32'h0000_3014);
    go_to(32'h3010);
    check("hyst_ctr10_pred", 32'(pred_taken), 32'd1);
    set_ex(1, 1, 0, 0, 32'h3010, 32'h3000, 1, 32'h3000);
    step(); idle();
    go_to(32'h3010);
    check("hyst_ctr01_pred", 32'(pred_taken), 32'd0);

    // Mispredict beats stall; stall alone holds.
    stall = 1'b1;
    set_ex(1, 1, 0, 1, 32'h3020, 32'h3100, 0, '0);
    step(); idle();
    check("stall_mis_pc", pc, 32'h0000_3100);
    step();
    check("stall_hold", pc, 32'h0000_3100);
    stall = 1'b0;

    // Aliasing: 0x3050 shares the line of 0x3010.
    set_ex(1, 1, 0, 1, 32'h3010, 32'h3000, 0, '0);
    step(); idle();
    go_to(32'h3010);
    check("alias_before", 32'(pred_taken), 32'd1);
    set_ex(1, 1, 0, 1, 32'h3050, 32'h3200, 0, '0);
    step(); idle();
    go_to(32'h3010);
    check("alias_evict", 32'(pred_taken), 32'd0);

    // Address wrap and target alignment.
    set_ex(1, 0, 1, 1, 32'h3000, 32'hFFFF_FFFC, 0, '0);
    step(); idle();
    check("wrap_at", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_zero", pc, 32'h0000_0000);
    set_ex(1, 0, 1, 1, 32'h0, 32'h0040_0001, 0, '0);
    step(); idle();
    check("jr_align", pc, 32'h0040_0000);

    // Randomized resolutions in a small, heavily aliased address window.
    for (int n = 0; n < 1500; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      k = int'($urandom_range(0, 3));
      t = 32'h3000 + 32'd4 * $urandom_range(0, 47);
      if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(0, 3));
      set_ex($urandom_range(0, 1) == 1, (k == 1) || (k == 3), k == 2,
             (k == 2) ? 1'b1 : ($urandom_range(0, 1) == 1),
             32'h3000 + 32'd4 * $urandom_range(0, 47), t,
             $urandom_range(0, 1) == 1,
             ($urandom_range(0, 2) != 0) ? t : 32'h3000 + 32'd4 * $urandom_range(0, 47));
      if ($urandom_range(0, 199) == 0) mid_reset();
      step();
    end
    idle();
    stall = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Registered program-counter stage with a parametrised, direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces the purely combinational next-PC selection with a fetch-stage PC register. The register predicts taken branches/jumps at fetch, accepts resolved outcomes from the execute stage, and issues a single-cycle redirect on misprediction. It sits at the front of the MIPS pipeline, driving instruction-memory address and feeding prediction bits down the pipe.

## Interface
- AW, 32, address width in bits (≥ 8)
- BTB_DEPTH, 16, BTB entries; power of two, ≥ 2; IW = log2(BTB_DEPTH)
- RESET_PC, 32'h0000_3000, PC value after reset (bits [1:0] must be 00)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC (fetch bubble)
- pc  out  AW  current fetch address
- pc_plus4  out  AW  pc + 4
- pred_taken  out  1  prediction for current pc
- pred_target  out  AW  predicted target (valid when pred_taken)
- ex_valid  in  1  resolution bus valid
- ex_pc  in  AW  PC of resolving instruction
- ex_is_branch  in  1  conditional branch (beq/bne/blez/bgtz/bltz/bgez)
- ex_is_jump  in  1  unconditional j/jal/jr
- ex_taken  in  1  actual outcome (forced 1 by source for jumps)
- ex_target  in  AW  actual target
- ex_pred_taken  in  1  prediction carried with instruction
- ex_pred_target  in  AW  predicted target carried with instruction
- mispredict  out  1  redirect this cycle; pipeline flushes younger stages

## Operation
- Lookup: idx = pc[IW+1:2], tag = pc[AW-1:IW+2]. hit = valid[idx] & tag match. pred_taken = hit & ctr[idx][1]; pred_target = tgt[idx] (zero-extended low bits 00). Combinational from stored state.
- mispredict = ex_valid & (ex_is_branch | ex_is_jump) & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
- redirect = ex_taken ? {ex_target[AW-1:2],2'b00} : ex_pc + 4.
- Next PC priority: mispredict → redirect; else stall → hold; else pred_taken → pred_target; else pc + 4. Mispredict overrides stall.
- BTB update on ex_valid & (ex_is_branch | ex_is_jump), indexed/tagged by ex_pc:
  - taken, entry miss or tag differs: allocate valid=1, new tag, tgt=ex_target; ctr = 11 for jump, 10 for branch.
  - taken, hit: tgt=ex_target; ctr saturating +1 (jump: force 11).
  - not taken, hit: ctr saturating −1 (entry stays valid).
  - not taken, miss: no change.
- Updates are independent of stall and of mispredict.
- Arithmetic: all adds unsigned mod 2^AW; 0x…FFFC + 4 wraps to 0. pc[1:0] always 00.

## Timing
- Reset (async assert, sync-free release): pc = RESET_PC, all valid = 0, ctr = 01, tgt = 0. Consequently pred_taken = 0, pred_target = 0, pc_plus4 = RESET_PC + 4. mispredict is combinational from inputs only.
- Reset asserted mid-operation clears state immediately; in-flight ex_* inputs are ignored while rst_n = 0.
- PC update latency: 1 cycle. Redirect presented in cycle n sets pc = redirect at edge ending cycle n.
- BTB write at edge ending cycle n; visible to lookups from cycle n+1. Same-cycle lookup of the index being written sees the old contents.
- Predicted-taken fetch at cycle n: pc = pred_target in cycle n+1 (zero-bubble).
- stall high with no mispredict: pc, pred outputs stable.

## Test plan
- Reset: rst_n=0 then release → pc=0x3000, pred_taken=0, pc_plus4=0x3004; three unstalled cycles → 0x3004, 0x3008, 0x300C.
- Train loop: branch at 0x3010 to 0x3000 resolved taken (pred 0) → mispredict=1, next pc=0x3000; next fetch of 0x3010 → pred_taken=1, pred_target=0x3000, no mispredict on resolve.
- Counter hysteresis: after ctr=11, one not-taken resolve → mispredict, redirect 0x3014, ctr=10, still predicts taken; second not-taken → ctr=01, predicts not-taken.
- Stall vs mispredict: stall=1 and mispredict same cycle with ex_taken=1, ex_target=0x3100 → pc=0x3100 next cycle; stall alone → pc holds.
- Aliasing: 16 entries, branches at 0x3010 and 0x3050 (same idx, different tag) → second allocation evicts first; fetch at 0x3010 → pred_taken=0.
- Wrap, AW=32: pc=0xFFFF_FFFC, no prediction → pc=0x0000_0000; jr target 0x0040_0001 resolved → pc=0x0040_0000.
